// File: rtl/npu_axi_pkg.sv
// Shared AXI constants and arbiter state type for the NPU fetch-side AXI blocks.
// Pure declarations: no logic, no latency, no backpressure.
package npu_axi_pkg;

    localparam int          AXI_BEAT_BYTES = 32;
    localparam logic [2:0]  AXI_SIZE_32B   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority select: first asserted req after index last, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_picker #(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester overwrites the result.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_CLIENTS);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin share of one AXI read port among NUM_CLIENTS, one burst in flight.
// AR leaves 1 cycle after client accept; R is combinational passthrough with rready from the granted client.
module axi_rd_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        c_arvalid,
    output logic [NUM_CLIENTS-1:0]        c_arready,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] c_araddr,
    input  logic [NUM_CLIENTS*8-1:0]      c_arlen,
    output logic [NUM_CLIENTS-1:0]        c_rvalid,
    input  logic [NUM_CLIENTS-1:0]        c_rready,
    output logic [DATA_W-1:0]             c_rdata,
    output logic                          c_rlast,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic                          m_axi_rlast,
    output logic                          busy,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_idx,
    output logic                          err_len
);
    import npu_axi_pkg::*;

    localparam int GW = $clog2(NUM_CLIENTS);

    arb_state_t        state, state_nxt;
    logic [GW-1:0]     grant_q, last_q, pick_idx;
    logic              pick_found;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [8:0]        beat_cnt;
    logic              err_q;
    logic              r_hs;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (GW)
    ) u_picker (
        .req   (c_arvalid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        c_arready    = '0;
        c_rvalid     = '0;
        m_axi_rready = 1'b0;
        r_hs         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    c_arready[pick_idx] = 1'b1;
                    state_nxt           = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_arready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                c_rvalid[grant_q] = m_axi_rvalid;
                m_axi_rready      = c_rready[grant_q];
                r_hs              = m_axi_rvalid && c_rready[grant_q];
                if (r_hs && m_axi_rlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q  <= '0;
            last_q   <= GW'(NUM_CLIENTS - 1);
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && pick_found) begin
                grant_q  <= pick_idx;
                addr_q   <= c_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
                len_q    <= c_arlen[int'(pick_idx)*8 +: 8];
                beat_cnt <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 9'd1;
                // Early or late rlast is flagged; a late one still ends the burst on rlast.
                if (m_axi_rlast) begin
                    if (beat_cnt != {1'b0, len_q}) err_q <= 1'b1;
                    last_q <= grant_q;
                end else if (beat_cnt == {1'b0, len_q}) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign m_axi_arvalid = (state == ST_ADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXI_SIZE_32B;
    assign c_rdata       = m_axi_rdata;
    assign c_rlast       = m_axi_rlast;
    assign busy          = (state != ST_IDLE);
    assign grant_idx     = grant_q;
    assign err_len       = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter with a byte-addressed memory slave (mem[j] = j[7:0]).
module tb_axi_rd_arbiter;

    localparam int NC = 2;
    localparam int AW = 64;
    localparam int DW = 256;

    logic             clk, rst_n;
    logic [NC-1:0]    c_arvalid, c_arready, c_rvalid, c_rready;
    logic [NC*AW-1:0] c_araddr;
    logic [NC*8-1:0]  c_arlen;
    logic [DW-1:0]    c_rdata;
    logic             c_rlast;
    logic             m_axi_arvalid, m_axi_arready;
    logic [AW-1:0]    m_axi_araddr;
    logic [7:0]       m_axi_arlen;
    logic [2:0]       m_axi_arsize;
    logic             m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [DW-1:0]    m_axi_rdata;
    logic             busy, err_len;
    logic [0:0]       grant_idx;

    axi_rd_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_arvalid(c_arvalid), .c_arready(c_arready), .c_araddr(c_araddr), .c_arlen(c_arlen),
        .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata), .c_rlast(c_rlast),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast),
        .busy(busy), .grant_idx(grant_idx), .err_len(err_len)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; bit gap; } ar_t;
    typedef struct { int client; logic [255:0] data; logic last; } beat_t;

    ar_t   ar_q[$];
    beat_t r_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_cnt = 0;
    int last_rlast_cyc = 0;
    int pend[NC];
    bit stall_mode = 0;
    bit err_inject = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [255:0] mk_data(input logic [63:0] a);
        logic [255:0] d;
        d = '0;
        for (int b = 0; b < 32; b++) d[b*8 +: 8] = 8'(a + 64'(b));
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_burst(input int client, input logic [63:0] addr, input logic [7:0] len,
                              input int nbeats, input bit gap);
        ar_q.push_back('{addr, len, gap});
        for (int k = 0; k < nbeats; k++)
            r_q.push_back('{client, mk_data(addr + 64'(32 * k)), (k == nbeats - 1)});
    endtask

    task automatic set_client(input int client, input logic [63:0] addr, input logic [7:0] len);
        c_araddr[client*AW +: AW] = addr;
        c_arlen[client*8 +: 8]    = len;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if (r_q.size() == 0 && ar_q.size() == 0 && !busy && pend[0] == 0 && pend[1] == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout, %0d beats and %0d ARs outstanding", name, r_q.size(), ar_q.size());
            r_q.delete();
            ar_q.delete();
            pend = '{0, 0};
        end
    endtask

    task automatic wait_rx(input string name, input int target, input int budget);
        bit ok;
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #2;
            if (rx_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout, got %0d beats need %0d", name, rx_cnt, target);
        end
    endtask

    // Client drivers: hold arvalid while requests are pending, drop after the accepting edge.
    initial begin
        logic [NC-1:0] acc;
        c_arvalid = '0;
        c_rready  = '0;
        forever begin
            @(negedge clk);
            acc = c_arvalid & c_arready;
            @(posedge clk); #1;
            for (int i = 0; i < NC; i++) begin
                if (rst_n && acc[i] && pend[i] > 0) pend[i]--;
                c_arvalid[i] = rst_n && (pend[i] > 0);
                c_rready[i]  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Memory slave: one burst at a time, rvalid held while active.
    initial begin
        bit          s_active, hs_ar, hs_r;
        logic [63:0] s_addr, ar_addr;
        logic [7:0]  ar_len;
        int          s_k, s_n;
        s_active = 0; s_addr = '0; s_k = 0; s_n = 1;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            hs_ar   = m_axi_arvalid && m_axi_arready;
            hs_r    = m_axi_rvalid && m_axi_rready;
            ar_addr = m_axi_araddr;
            ar_len  = m_axi_arlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                s_active = 0;
            end else begin
                if (hs_r) begin
                    if (s_k == s_n - 1) s_active = 0;
                    s_k++;
                end
                if (hs_ar) begin
                    s_active = 1;
                    s_addr   = ar_addr;
                    s_k      = 0;
                    s_n      = err_inject ? 2 : int'(ar_len) + 1;
                end
            end
            m_axi_rvalid = s_active;
            m_axi_rdata  = mk_data(s_addr + 64'(32 * s_k));
            m_axi_rlast  = s_active && (s_k == s_n - 1);
        end
    end

    // Monitor: compares AR and R traffic against the expected queues.
    initial forever begin
        int ci;
        ar_t e;
        beat_t b;
        @(negedge clk);
        if (rst_n) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) fail("ar_unexpected");
                else begin
                    e = ar_q.pop_front();
                    chk("ar_addr", m_axi_araddr, e.addr);
                    chk("ar_len", m_axi_arlen, e.len);
                    chk("ar_size", m_axi_arsize, 3'd5);
                    if (e.gap) chk("ar_gap", cyc - last_rlast_cyc, 2);
                end
            end
            if (|c_rvalid) begin
                ci = 0;
                for (int i = 0; i < NC; i++) if (c_rvalid[i]) ci = i;
                if ($countones(c_rvalid) != 1) fail("rvalid_onehot");
                else if (r_q.size() == 0) fail("r_unexpected");
                else begin
                    chk("rvalid_client", ci, r_q[0].client);
                    chk("rready_mirror", m_axi_rready, c_rready[ci]);
                    if (c_rready[ci]) begin
                        b = r_q.pop_front();
                        chk("r_data", c_rdata, b.data);
                        chk("r_last", c_rlast, b.last);
                        rx_cnt++;
                        if (c_rlast) last_rlast_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        pend = '{0, 0};
        c_araddr = '0;
        c_arlen = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_araddr", m_axi_araddr, 64'h0);
        chk("rst_arlen", m_axi_arlen, 8'h0);
        chk("rst_arready", c_arready, 2'b00);
        chk("rst_rvalid", c_rvalid, 2'b00);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_err", err_len, 1'b0);
        chk("rst_grant", grant_idx, 1'b0);
        rst_n = 1'b1;

        // Continuous requests from both clients: strict rotation starting at client 0.
        set_client(0, 64'h0, 8'd0);
        set_client(1, 64'h1000, 8'd0);
        push_burst(0, 64'h0, 8'd0, 1, 0);
        push_burst(1, 64'h1000, 8'd0, 1, 1);
        push_burst(0, 64'h0, 8'd0, 1, 1);
        push_burst(1, 64'h1000, 8'd0, 1, 1);
        pend = '{2, 2};
        wait_done("rotate", 200);
        chk("rotate_grant", grant_idx, 1'b1);

        // Single len-3 burst from client 0.
        set_client(0, 64'h100, 8'd3);
        push_burst(0, 64'h100, 8'd3, 4, 0);
        pend[0] = 1;
        wait_done("single", 200);
        chk("single_err", err_len, 1'b0);
        chk("single_busy", busy, 1'b0);
        chk("single_grant", grant_idx, 1'b0);

        // Client 1 arrives mid-burst; its AR follows the rlast handshake by exactly 2 cycles.
        set_client(0, 64'h2000, 8'd7);
        set_client(1, 64'h3000, 8'd1);
        push_burst(0, 64'h2000, 8'd7, 8, 0);
        push_burst(1, 64'h3000, 8'd1, 2, 1);
        base = rx_cnt;
        pend[0] = 1;
        wait_rx("mid_wait", base + 3, 200);
        pend[1] = 1;
        wait_done("mid", 300);

        // Random consumer stalls on a len-15 burst.
        stall_mode = 1;
        set_client(1, 64'h4000, 8'd15);
        push_burst(1, 64'h4000, 8'd15, 16, 0);
        pend[1] = 1;
        wait_done("stall", 500);
        stall_mode = 0;

        // Early rlast on beat 2 of a len-3 burst, then a clean burst.
        err_inject = 1;
        set_client(0, 64'h800, 8'd3);
        push_burst(0, 64'h800, 8'd3, 2, 0);
        pend[0] = 1;
        wait_done("early_last", 200);
        err_inject = 0;
        chk("early_err", err_len, 1'b1);
        chk("early_idle", busy, 1'b0);
        set_client(1, 64'h900, 8'd2);
        push_burst(1, 64'h900, 8'd2, 3, 0);
        pend[1] = 1;
        wait_done("after_err", 200);
        chk("err_sticky", err_len, 1'b1);

        // Reset during the second beat of a client 1 burst.
        set_client(1, 64'h5000, 8'd3);
        push_burst(1, 64'h5000, 8'd3, 4, 0);
        base = rx_cnt;
        pend[1] = 1;
        wait_rx("rst_wait", base + 1, 200);
        chk("pre_rst_rvalid", c_rvalid, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", c_rvalid, 2'b00);
        chk("mid_rst_rready", m_axi_rready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_err", err_len, 1'b0);
        r_q.delete();
        ar_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_client(0, 64'h6000, 8'd0);
        set_client(1, 64'h7000, 8'd0);
        push_burst(0, 64'h6000, 8'd0, 1, 0);
        push_burst(1, 64'h7000, 8'd0, 1, 1);
        pend = '{1, 1};
        wait_done("post_rst", 200);
        chk("post_rst_grant", grant_idx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one 256-bit AXI read master port among NUM_CLIENTS read requesters, e.g. NPU weight and activation fetch engines.
- Round-robin arbitration, one outstanding burst at a time.
- Routes R beats back to the granted client and checks burst length against rlast.
- Sits between the NPU fetch engines and the AXI memory (the AXI memory model in simulation).

Parameters:
- NUM_CLIENTS, 2, number of requesters (2..8).
- ADDR_W, 64, address width.
- DATA_W, 256, data width. Fixed beat size of 32 bytes; arsize = 3'd5.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- c_arvalid  in  NUM_CLIENTS  per-client request valid.
- c_arready  out  NUM_CLIENTS  per-client request accept.
- c_araddr  in  NUM_CLIENTS*ADDR_W  flattened; client i at [i*ADDR_W +: ADDR_W].
- c_arlen  in  NUM_CLIENTS*8  flattened burst length minus 1.
- c_rvalid  out  NUM_CLIENTS  per-client read data valid.
- c_rready  in  NUM_CLIENTS  per-client read data ready.
- c_rdata  out  DATA_W  shared read data bus; qualify with c_rvalid[i].
- c_rlast  out  1  last beat of burst; qualify with c_rvalid.
- m_axi_arvalid  out  1  master read address valid.
- m_axi_arready  in  1  master read address ready.
- m_axi_araddr  out  ADDR_W  master read address.
- m_axi_arlen  out  8  master burst length.
- m_axi_arsize  out  3  constant 3'd5.
- m_axi_rvalid  in  1  master read data valid.
- m_axi_rready  out  1  master read data ready.
- m_axi_rdata  in  DATA_W  master read data.
- m_axi_rlast  in  1  master last beat.
- busy  out  1  FSM not in IDLE.
- grant_idx  out  $clog2(NUM_CLIENTS)  current or last grant.
- err_len  out  1  sticky burst-length error flag.

Behaviour:
- Reset (async assert, sync deassert):
  - FSM = IDLE; m_axi_arvalid = 0; m_axi_araddr = 0; m_axi_arlen = 0.
  - c_arready = 0; c_rvalid = 0; m_axi_rready = 0; busy = 0; err_len = 0.
  - grant_idx = 0; last_grant = NUM_CLIENTS-1, so client 0 wins first.
  - Reset mid-burst abandons the burst; no beats are forwarded after reset.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Combinationally pick the first requesting client in order last_grant+1, last_grant+2, ... (mod NUM_CLIENTS).
  - If one is found: c_arready[g] = 1 that cycle (the only combinational ready). Latch addr, len and g. Set beat_cnt = 0. Go to ADDR.
  - If none: stay in IDLE.
- ADDR:
  - m_axi_arvalid = 1 (registered), so the AR valid appears 1 cycle after the client handshake.
  - Address and length stay stable until m_axi_arready.
  - On handshake: arvalid drops next cycle; go to DATA.
- DATA:
  - Combinational passthrough: c_rvalid[g] = m_axi_rvalid, m_axi_rready = c_rready[g]. All other c_rvalid are 0.
  - c_rdata = m_axi_rdata; c_rlast = m_axi_rlast.
  - Each R handshake increments beat_cnt (9 bits).
  - On the rlast handshake: if beat_cnt+1 != len+1, set err_len. Then last_grant = g and go to IDLE.
  - A handshake without rlast when beat_cnt == len also sets err_len, but the FSM still waits for rlast.
- m_axi_rready = 0 outside DATA.
- Back-to-back bursts: after the rlast handshake, IDLE can grant again the very next cycle.
- Minimum gap between bursts is 2 cycles (IDLE, ADDR).
- A client's request held during another client's burst is served next in round-robin order.
- A client must hold c_arvalid, addr and len until c_arready. Dropping c_arvalid before grant is allowed.
- Simultaneous requests from all clients: strict rotation, so each client is granted once per NUM_CLIENTS bursts.
- busy = (state != IDLE).
- grant_idx is registered and updates when a grant is made.

Decomposition:
- Shared package npu_axi_pkg:
  - AXI_BEAT_BYTES = 32.
  - AXI_SIZE_32B = 3'd5.
  - State enum type arb_state_t.
- Sub-module rr_picker (NUM_CLIENTS param):
  - Combinational round-robin priority select.
  - Inputs: req vector, last index. Outputs: found, idx.
  - Reused by a future write arbiter.

Test Plan:
- Memory model preloaded with mem[j] = j[7:0]. Client 0 requests addr 0x100, len 3 → one AR with addr 0x100, len 3, size 5; 4 beats to client 0, beat k byte 0 = 0x00 + 32k (mod 256); c_rlast on beat 4 only; err_len stays 0; busy returns to 0.
- Both clients request continuously (c0 addr 0x0, c1 addr 0x1000, len 0) → grant order 0,1,0,1; c_rvalid[1] never high during client 0 bursts.
- Client 1 asserts a request mid-way through a client 0 len-7 burst → client 1's AR issues exactly 2 cycles after client 0's rlast handshake; client 0 data is unaffected.
- Random c_rready stalls on a len-15 burst → m_axi_rready mirrors c_rready[g]; all 16 beats arrive in address order, none lost or duplicated.
- Slave driving rlast on beat 2 of a len-3 burst → err_len = 1 and sticky; FSM returns to IDLE; the next burst completes normally.
- rst_n asserted during beat 2 of a burst → all valids 0 immediately; after release, client 0 wins first.
